i2s_deserialize: RTL and testbench
==================================

# i2s_deserialize

Receive side of the team's serial audio link: samples a one-bit serial stream plus word-select on every `clk` edge, reassembles LSB-first `WIDTH`-bit words, and pairs them into left/right stereo frames. Each completed frame is presented on a valid/ready output port for the downstream sample consumer. This block is the mirror of the 24-bit LSB-first shifter on the transmit side.

## Interface
- `WIDTH`, 24, bits per channel word; legal range 2..31.
- `clk`  in  1  bit clock; one serial bit is sampled per rising edge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous reset, active-high.
- `sd`  in  1  serial data bit.
- `ws`  in  1  word select: 0 = left word, 1 = right word.
- `left_data`  out  WIDTH  left sample of the presented frame.
- `right_data`  out  WIDTH  right sample of the presented frame.
- `valid`  out  1  frame present on outputs.
- `ready`  in  1  consumer accepts the frame when `valid && ready`.
- `overrun`  out  1  one-cycle pulse when a completed frame is dropped.
- `short_word`  out  1  one-cycle pulse when a word ends before `WIDTH` bits.

## Operation
- `ws_q` holds `ws` from the previous cycle. A word start is any cycle with `ws != ws_q`. The `sd` bit in that same cycle is bit 0, so there is no one-bit I2S delay.
- Bits are LSB first: bit k of a word is sampled k cycles after the word start.
- The bit counter is 5 bits wide. It resets to 0 at each word start and saturates at `WIDTH`.
- Bits arriving after `WIDTH` bits have been captured in the same `ws` half are ignored.
- FSM states:
  - SYNC: reset state. Discards all bits. Leaves on the first word start with `ws`=0 (falling `ws`), going to LEFT and capturing bit 0.
  - LEFT: shifts into the left shift register. Goes to RIGHT on a word start (rising `ws`).
    - If fewer than `WIDTH` bits were captured, pulse `short_word` and set `left_ok`=0.
    - Otherwise set `left_ok`=1.
  - RIGHT: shifts into the right shift register.
    - On the cycle the `WIDTH`th right bit is captured with `left_ok`=1, the frame is complete.
    - Goes to LEFT on a word start (falling `ws`). If fewer than `WIDTH` right bits were captured, pulse `short_word`; no frame completes.
- Frame completion:
  - If `valid`=0, or `valid && ready` in the same cycle: load the output registers and set `valid`=1.
  - Otherwise: keep the old frame, drop the new one, and pulse `overrun`.
- `valid` clears on `valid && ready` unless a frame completes in that same cycle.
- The output registers are stable while `valid`=1 and not accepted.
- `reset` mid-word or mid-frame: the partial word is discarded, the FSM returns to SYNC, and a pending output frame is dropped.

## Timing
- Reset values:
  - `valid`=0, `overrun`=0, `short_word`=0.
  - `left_data`=0, `right_data`=0.
  - `ws_q`=1, so a `ws` held low through reset produces a word start on the first cycle after reset.
  - State SYNC, bit counter 0.
- Latency: `valid` and the data are asserted in the cycle after the edge that samples the last right bit.
- `overrun` and `short_word` are registered and are high for exactly one cycle.
- Full throughput: one frame per 2×`WIDTH` clocks, with `ready` tied high and no stall.
- A `ws` toggle and the `WIDTH`th bit cannot coincide, because the toggle starts a new word. A word of exactly `WIDTH` bits followed immediately by a toggle is legal and error-free.

## Structure
- Package `i2s_pkg` holds:
  - `I2S_WORD_BITS` = 24, the default for `WIDTH`.
  - The FSM state enum: SYNC, LEFT, RIGHT.
  - Bit counter width constant = 5.
- Sub-module `word_capture` (parameter `WIDTH`), instantiated twice (left, right):
  - Inputs: `clk`, `reset`, `start`, `en`, `sd`.
  - Outputs: `word` (`WIDTH`), `done` (pulse on the `WIDTH`th bit), `count`.
  - Contains the LSB-first shift register (bit k lands in position k) and the saturating counter.
- Top level holds `ws` edge detection, the FSM, the output holding register and the handshake.

## Test plan
- Reset, then `ws`=0 for 24 clocks with left word 0xA5F00F, then `ws`=1 with right word 0x123456 sent LSB first, `ready`=1 -> one-cycle `valid` with `left_data`=0xA5F00F, `right_data`=0x123456, one clock after the last right bit.
- `ready`=0 across two consecutive complete frames -> first frame held unchanged, `overrun` pulses once at the second frame's completion; then `ready`=1 -> first frame accepted, `valid` falls.
- `valid`=1 and `ready` asserted exactly in the completion cycle of the next frame -> new frame loaded, `valid` stays 1, no `overrun`.
- `ws` toggles after only 20 left bits -> `short_word` pulse and no `valid` for that frame; the next full frame is received correctly.
- Stream starts with `ws`=1 (right half) -> ignored until the first falling `ws`; 30 bits per half with the low 24 = 0xFFFFFF/0x000001 -> frames `left_data`=0xFFFFFF, `right_data`=0x000001.
- `reset` pulsed for 1 cycle in the middle of a right word -> no `valid` for that frame, outputs 0, and reception resumes at the next falling `ws`.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared definitions for the serial audio receive path: default word size,
// bit-counter width and the receiver frame-alignment states.
package i2s_pkg;

    localparam int I2S_WORD_BITS = 24;
    localparam int CNT_W         = 5;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

endpackage

// File: rtl/word_capture.sv
// LSB-first word assembler: bit k of a word lands in position k. The counter
// holds the number of bits captured in the current word and saturates at
// WIDTH, so trailing bits of an over-long word are ignored.
module word_capture
    import i2s_pkg::*;
#(
    parameter int WIDTH = I2S_WORD_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             en,
    input  logic             sd,
    output logic [WIDTH-1:0] word,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic capture;

    // A start always loads bit 0; later bits are taken only until the word is full
    assign capture = en && !start && (count != FULL);
    assign done    = capture && (count == LAST);

    // Bit counter: restarts at 1 because the start cycle already carries bit 0
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && start) begin
            count <= CNT_W'(1);
        end else if (capture) begin
            count <= count + CNT_W'(1);
        end
    end

    // Shift register: datapath only, no reset needed
    always_ff @(posedge clk) begin
        if (en && start) begin
            word <= {{(WIDTH-1){1'b0}}, sd};
        end else if (capture) begin
            word[count] <= sd;
        end
    end

endmodule

// File: rtl/i2s_deserialize.sv
// Serial audio receiver: detects word starts from ws edges, aligns to the
// first left word, assembles left/right words and presents complete stereo
// frames on a valid/ready port with overrun and short-word pulses.
module i2s_deserialize
    import i2s_pkg::*;
#(
    parameter int WIDTH = I2S_WORD_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sd,
    input  logic             ws,
    output logic [WIDTH-1:0] left_data,
    output logic [WIDTH-1:0] right_data,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    output logic             short_word
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);

    state_t           state, state_nxt;
    logic             ws_q;
    logic             word_start;
    logic             start_l, en_l, start_r, en_r;
    logic [WIDTH-1:0] word_l, word_r;
    logic             done_l, done_r;
    logic [CNT_W-1:0] count_l, count_r;
    logic             left_ok;
    logic             short_set;
    logic             frame_done;
    logic             accept;
    logic [WIDTH-1:0] right_next;

    // Any ws change starts a word, and the sd bit of that same cycle is bit 0
    assign word_start = (ws != ws_q);

    // Left capture runs while ws is low once aligned; a falling ws in SYNC is
    // the alignment point. Right capture runs only after alignment.
    assign start_l = word_start && !ws;
    assign en_l    = !ws && ((state != SYNC) || word_start);
    assign start_r = word_start && ws;
    assign en_r    = ws && (state != SYNC);

    assign frame_done = (state == RIGHT) && done_r && left_ok;
    assign accept     = valid && ready;

    word_capture #(.WIDTH(WIDTH)) u_left (
        .clk   (clk),
        .reset (reset),
        .start (start_l),
        .en    (en_l),
        .sd    (sd),
        .word  (word_l),
        .done  (done_l),
        .count (count_l)
    );

    word_capture #(.WIDTH(WIDTH)) u_right (
        .clk   (clk),
        .reset (reset),
        .start (start_r),
        .en    (en_r),
        .sd    (sd),
        .word  (word_r),
        .done  (done_r),
        .count (count_r)
    );

    // Next state and short-word detection on each half boundary
    always_comb begin
        state_nxt = state;
        short_set = 1'b0;
        case (state)
            SYNC: begin
                if (word_start && !ws) begin
                    state_nxt = LEFT;
                end
            end
            LEFT: begin
                if (word_start) begin
                    state_nxt = RIGHT;
                    short_set = (count_l != FULL);
                end
            end
            RIGHT: begin
                if (word_start) begin
                    state_nxt = LEFT;
                    short_set = (count_r != FULL);
                end
            end
            default: begin
                state_nxt = SYNC;
            end
        endcase
    end

    // The last right bit is still on sd in the completion cycle
    always_comb begin
        right_next            = word_r;
        right_next[WIDTH-1]   = sd;
    end

    // Control state: alignment FSM, left-word status, handshake and pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_q       <= 1'b1;
            state      <= SYNC;
            left_ok    <= 1'b0;
            valid      <= 1'b0;
            overrun    <= 1'b0;
            short_word <= 1'b0;
        end else begin
            ws_q       <= ws;
            state      <= state_nxt;
            short_word <= short_set;
            overrun    <= frame_done && valid && !ready;
            if (start_l) begin
                left_ok <= 1'b0;
            end else if (done_l) begin
                left_ok <= 1'b1;
            end
            if (frame_done) begin
                valid <= 1'b1;
            end else if (accept) begin
                valid <= 1'b0;
            end
        end
    end

    // Output holding register: only reloaded when the slot is free or freeing
    always_ff @(posedge clk) begin
        if (reset) begin
            left_data  <= '0;
            right_data <= '0;
        end else if (frame_done && (!valid || ready)) begin
            left_data  <= word_l;
            right_data <= right_next;
        end
    end

endmodule

// File: tb/tb_i2s_deserialize.sv
// Bench for i2s_deserialize: directed frame table with hand-derived results,
// hand-written multi-cycle sequences, and a randomized stream compared every
// cycle against a bit-counting reference model.
module tb_i2s_deserialize;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         reset, sd, ws, ready;
    logic [W-1:0] left_data, right_data;
    logic         valid, overrun, short_word;

    int tests = 0;
    int fails = 0;

    // observers accumulated from DUT outputs
    int vcnt, vlow, ovcnt, swcnt;

    // reference model state
    logic        m_wsp, m_sync, m_lok, m_valid, m_ovr, m_sw;
    int          m_n;
    logic [31:0] m_acc, m_lval;
    logic [W-1:0] m_l, m_r;

    typedef struct {
        logic [31:0] lw;
        logic [31:0] rw;
        int          nl;
        int          nr;
        int          rmode;
        int          vcnt;
        int          vend;
        logic [23:0] el;
        logic [23:0] er;
        int          sw;
        int          ov;
    } rec_t;

    rec_t tbl[8];

    always #5 clk = ~clk;

    i2s_deserialize #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .sd         (sd),
        .ws         (ws),
        .left_data  (left_data),
        .right_data (right_data),
        .valid      (valid),
        .ready      (ready),
        .overrun    (overrun),
        .short_word (short_word)
    );

    // Stream model: count bits in the current ws half, keep the finished left
    // word, and emit a frame when the right half reaches W bits.
    task automatic model_step(input logic r, input logic s, input logic w, input logic rd);
        logic take;
        logic frame;
        if (r) begin
            m_wsp = 1'b1; m_sync = 1'b0; m_n = 0; m_acc = '0; m_lok = 1'b0;
            m_lval = '0; m_valid = 1'b0; m_l = '0; m_r = '0; m_ovr = 1'b0; m_sw = 1'b0;
            return;
        end
        take  = m_valid && rd;
        frame = 1'b0;
        m_ovr = 1'b0;
        m_sw  = 1'b0;
        if (w != m_wsp) begin
            if (m_sync && m_n < W) m_sw = 1'b1;
            if (w) begin
                m_lok  = m_sync && (m_n == W);
                m_lval = m_acc;
            end else begin
                m_sync = 1'b1;
            end
            m_n   = 0;
            m_acc = '0;
        end
        if (m_sync && m_n < W) begin
            m_acc[m_n] = s;
            m_n++;
            if (w && m_n == W && m_lok) frame = 1'b1;
        end
        if (frame) begin
            if (!m_valid || take) begin
                m_valid = 1'b1;
                m_l = m_lval[W-1:0];
                m_r = m_acc[W-1:0];
            end else begin
                m_ovr = 1'b1;
            end
        end else if (take) begin
            m_valid = 1'b0;
        end
        m_wsp = w;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        vcnt = 0; vlow = 0; ovcnt = 0; swcnt = 0;
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge
    task automatic cyc(input logic s, input logic w, input logic rd, input logic r);
        sd = s; ws = w; ready = rd; reset = r;
        @(posedge clk);
        model_step(r, s, w, rd);
        @(negedge clk);
        tests++;
        if ({valid, overrun, short_word, left_data, right_data} !==
            {m_valid, m_ovr, m_sw, m_l, m_r}) begin
            fails++;
            $display("FAIL cycle_model @%0t: got v=%b ov=%b sw=%b l=%h r=%h, expected v=%b ov=%b sw=%b l=%h r=%h",
                     $time, valid, overrun, short_word, left_data, right_data,
                     m_valid, m_ovr, m_sw, m_l, m_r);
        end
        if (valid) vcnt++; else vlow++;
        if (overrun) ovcnt++;
        if (short_word) swcnt++;
    endtask

    function automatic logic pick_ready(input int rmode);
        if (rmode == 2) return 1'($urandom_range(0, 1));
        return (rmode != 0);
    endfunction

    task automatic send_half(input logic [31:0] val, input int n, input logic w, input int rmode);
        for (int i = 0; i < n; i++) begin
            cyc(val[i], w, pick_ready(rmode), 1'b0);
        end
    endtask

    task automatic extras(input int n, input int rmode);
        for (int i = 0; i < n; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'b1, pick_ready(rmode), 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        int nl, nr;

        //           lw            rw            nl  nr  rm vcnt vend el          er          sw ov
        tbl[0] = '{32'h00A5F00F, 32'h00123456, 24, 24, 1,  1,  0, 24'hA5F00F, 24'h123456, 0, 0};
        tbl[1] = '{32'h00111111, 32'h00222222, 24, 24, 0,  3,  1, 24'h111111, 24'h222222, 0, 0};
        tbl[2] = '{32'h00333333, 32'h00444444, 24, 24, 0, 50,  1, 24'h111111, 24'h222222, 0, 1};
        tbl[3] = '{32'h00555555, 32'h00666666, 24, 24, 1,  1,  0, 24'h555555, 24'h666666, 0, 0};
        tbl[4] = '{32'h000ABCDE, 32'h000FEDCB, 20, 24, 1,  0,  0, 24'h555555, 24'h666666, 1, 0};
        tbl[5] = '{32'h0000C0DE, 32'h000BEEF1, 24, 24, 1,  1,  0, 24'h00C0DE, 24'h0BEEF1, 0, 0};
        // short right word: its short pulse appears at the next falling ws (record 7)
        tbl[6] = '{32'h00777777, 32'h00888888, 24, 10, 1,  0,  0, 24'h00C0DE, 24'h0BEEF1, 0, 0};
        tbl[7] = '{32'h2AFFFFFF, 32'h15000001, 30, 30, 1,  1,  0, 24'hFFFFFF, 24'h000001, 1, 0};

        sd = 1'b0; ws = 1'b1; ready = 1'b1; reset = 1'b1;

        // reset state
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_left", 32'(left_data), 32'd0);
        chk("reset_right", 32'(right_data), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_short", 32'(short_word), 32'd0);

        // stream starting in the right half is ignored until a falling ws
        clear_obs();
        extras(30, 1);
        chk("sync_no_valid", 32'(vcnt), 32'd0);
        chk("sync_no_short", 32'(swcnt), 32'd0);

        // directed frame table
        for (int i = 0; i < 8; i++) begin
            clear_obs();
            send_half(tbl[i].lw, tbl[i].nl, 1'b0, tbl[i].rmode);
            send_half(tbl[i].rw, tbl[i].nr, 1'b1, tbl[i].rmode);
            extras(2, tbl[i].rmode);
            chk($sformatf("rec%0d_vcnt", i), 32'(vcnt), 32'(tbl[i].vcnt));
            chk($sformatf("rec%0d_vend", i), 32'(valid), 32'(tbl[i].vend));
            chk($sformatf("rec%0d_left", i), 32'(left_data), 32'(tbl[i].el));
            chk($sformatf("rec%0d_right", i), 32'(right_data), 32'(tbl[i].er));
            chk($sformatf("rec%0d_short", i), 32'(swcnt), 32'(tbl[i].sw));
            chk($sformatf("rec%0d_overrun", i), 32'(ovcnt), 32'(tbl[i].ov));
        end

        // ready asserted exactly in the completion cycle of the next frame
        send_half(32'h000A0A0A, 24, 1'b0, 0);
        send_half(32'h000B0B0B, 24, 1'b1, 0);
        extras(2, 0);
        chk("hold_valid", 32'(valid), 32'd1);
        clear_obs();
        v = 32'h000D0D0D;
        send_half(32'h000C0C0C, 24, 1'b0, 0);
        send_half(v, 23, 1'b1, 0);
        cyc(v[23], 1'b1, 1'b1, 1'b0);
        extras(2, 0);
        chk("swap_no_overrun", 32'(ovcnt), 32'd0);
        chk("swap_valid_never_low", 32'(vlow), 32'd0);
        chk("swap_left", 32'(left_data), 32'h0C0C0C);
        chk("swap_right", 32'(right_data), 32'h0D0D0D);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("swap_accept", 32'(valid), 32'd0);

        // reset in the middle of a right word
        clear_obs();
        send_half(32'h000E0E0E, 24, 1'b0, 1);
        send_half(32'h000F0F0F, 10, 1'b1, 1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        send_half(32'h00FFFFFF, 14, 1'b1, 1);
        extras(2, 1);
        chk("midreset_no_valid", 32'(vcnt), 32'd0);
        chk("midreset_left", 32'(left_data), 32'd0);
        chk("midreset_right", 32'(right_data), 32'd0);
        chk("midreset_short", 32'(swcnt), 32'd0);
        clear_obs();
        send_half(32'h00123ABC, 24, 1'b0, 1);
        send_half(32'h00456DEF, 24, 1'b1, 1);
        extras(2, 1);
        chk("resume_vcnt", 32'(vcnt), 32'd1);
        chk("resume_left", 32'(left_data), 32'h123ABC);
        chk("resume_right", 32'(right_data), 32'h456DEF);

        // randomized stream against the reference model
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 19) == 0) begin
                cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
            end
            nl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : W;
            nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : W;
            send_half($urandom, nl, 1'b0, 2);
            send_half($urandom, nr, 1'b1, 2);
            if ($urandom_range(0, 2) == 0) extras(int'($urandom_range(1, 4)), 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
